// File: rtl/axis_mm_burst_writer.sv
// axis_mm_burst_writer: packs an AXI-Stream into AXI4 INCR write bursts.
// Beats are buffered in a FIFO. A burst is cut at MAX_BURST beats, at the first
// buffered tlast, or at a 4 KiB boundary, whichever comes first. Up to
// MAX_OUTSTANDING bursts may await their B response.
// Optional feature macro: AXIS_MM_RING_EN confines wr_ptr to a ring of
// RING_SIZE bytes that starts at the configured base address.
module axis_mm_burst_writer #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int ADDR_WIDTH      = 34,
  parameter int ID_WIDTH        = 6,
  parameter int AWID_VALUE      = 0,
  parameter int MAX_BURST       = 16,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RING_SIZE       = 2**20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  cfg_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [KEEP_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [31:0]           byte_count,
  output logic                  busy,
  output logic                  err
);
  localparam int SIZE = $clog2(KEEP_WIDTH);
  localparam int FAW  = $clog2(FIFO_DEPTH);
  localparam int CW   = (FAW + 1 > 14) ? FAW + 1 : 14;
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

  // beat FIFO
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [KEEP_WIDTH-1:0] r_mem_keep [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;
  logic [FAW-1:0]        r_wr, r_rd;
  logic [FAW:0]          r_cnt, r_lcnt;
  logic                  w_full, w_empty, w_push, w_pop, w_head_last;

  // burst control
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_awaddr, w_ptr_nxt, w_ptr_adv;
  logic [7:0]            r_awlen, r_beat;
  logic                  r_awvalid;
  logic [31:0]           r_acc, w_beat_bytes;
  logic [CW-1:0]         w_n_pkt, w_n_4k, w_n;
  logic                  w_start, w_cfg, w_aw_hs, w_b_hs;

  // outstanding / response tracking
  logic [OW-1:0]         r_out;
  logic [31:0]           r_bq [MAX_OUTSTANDING];
  logic [QW-1:0]         r_bq_wr, r_bq_rd;
  logic [31:0]           r_byte_cnt;
  logic                  r_err;
  logic                  w_unused;

  function automatic logic [31:0] f_popcnt(input logic [KEEP_WIDTH-1:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  function automatic logic [QW-1:0] f_qinc(input logic [QW-1:0] q);
    return (q == QW'(MAX_OUTSTANDING - 1)) ? '0 : q + QW'(1);
  endfunction

  assign w_full        = (r_cnt == (FAW+1)'(FIFO_DEPTH));
  assign w_empty       = (r_cnt == '0);
  assign s_axis_tready = !w_full;
  assign w_push        = s_axis_tvalid && !w_full;
  assign w_pop         = (r_state == S_W) && !w_empty && m_axi_wready;
  assign w_head_last   = r_mem_last[r_rd];

  // FIFO storage, no reset needed: contents are qualified by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= s_axis_tdata;
      r_mem_keep[r_wr] <= s_axis_tkeep;
      r_mem_last[r_wr] <= s_axis_tlast;
    end
  end

  // FIFO pointers, occupancy and count of buffered packet ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_lcnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + FAW'(1);
      if (w_pop)  r_rd <= r_rd + FAW'(1);
      r_cnt  <= r_cnt + (FAW+1)'(w_push) - (FAW+1)'(w_pop);
      r_lcnt <= r_lcnt + (FAW+1)'(w_push && s_axis_tlast) - (FAW+1)'(w_pop && w_head_last);
    end
  end

  // beats from the FIFO head up to and including the first buffered tlast
  always_comb begin : p_scan
    logic [FAW-1:0] idx;
    logic           found;
    w_n_pkt = CW'(MAX_BURST);
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < MAX_BURST; i++) begin
      idx = r_rd + FAW'(i);
      if (!found && (CW'(i) < CW'(r_cnt)) && r_mem_last[idx]) begin
        w_n_pkt = CW'(i + 1);
        found   = 1'b1;
      end
    end
  end

`ifdef AXIS_MM_RING_EN
  logic [ADDR_WIDTH-1:0] r_base, w_ring_end, w_ring_left;
  assign w_ring_end  = r_base + ADDR_WIDTH'(RING_SIZE);
  assign w_ring_left = w_ring_end - r_wr_ptr;
  assign w_ptr_adv   = (w_ptr_nxt == w_ring_end) ? r_base : w_ptr_nxt;
`else
  assign w_ptr_adv   = w_ptr_nxt;
`endif

  // burst length: packet end, MAX_BURST and 4 KiB boundary (and ring end)
  always_comb begin
    w_n_4k = CW'((13'h1000 - {1'b0, r_wr_ptr[11:0]}) >> SIZE);
    w_n    = w_n_pkt;
    if (w_n_4k < w_n) w_n = w_n_4k;
`ifdef AXIS_MM_RING_EN
    if (w_ring_left < (ADDR_WIDTH'(w_n) << SIZE)) w_n = CW'(w_ring_left >> SIZE);
`endif
  end

  assign w_start      = (r_state == S_IDLE) && (r_out < OW'(MAX_OUTSTANDING)) &&
                        ((r_cnt >= (FAW+1)'(MAX_BURST)) || (r_lcnt != '0));
  assign w_cfg        = cfg_valid && (r_state == S_IDLE) && (r_out == '0);
  assign w_aw_hs      = r_awvalid && m_axi_awready;
  assign w_b_hs       = m_axi_bvalid && m_axi_bready;
  assign w_ptr_nxt    = r_wr_ptr + ((ADDR_WIDTH'(r_awlen) + ADDR_WIDTH'(1)) << SIZE);
  assign w_beat_bytes = f_popcnt(r_mem_keep[r_rd]);

  // burst FSM: IDLE picks length, AW issues address, W drains N beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awvalid <= 1'b0;
      r_beat    <= '0;
      r_acc     <= '0;
`ifdef AXIS_MM_RING_EN
      r_base    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cfg) begin
            // a config load takes priority; any pending start retries next cycle
            r_wr_ptr <= cfg_base_addr;
`ifdef AXIS_MM_RING_EN
            r_base   <= cfg_base_addr;
`endif
          end else if (w_start) begin
            r_awaddr  <= r_wr_ptr;
            r_awlen   <= 8'(w_n - CW'(1));
            r_awvalid <= 1'b1;
            r_beat    <= '0;
            r_acc     <= '0;
            r_state   <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_wr_ptr  <= w_ptr_adv;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (w_pop) begin
            r_beat <= r_beat + 8'd1;
            r_acc  <= r_acc + w_beat_bytes;
            if (r_beat == r_awlen) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // per-burst byte totals, in issue order, waiting for their B response
  always_ff @(posedge clk) begin
    if (w_pop && m_axi_wlast) r_bq[r_bq_wr] <= r_acc + w_beat_bytes;
  end

  // outstanding count, byte counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_bq_wr    <= '0;
      r_bq_rd    <= '0;
      r_byte_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop && m_axi_wlast) r_bq_wr <= f_qinc(r_bq_wr);
      if (w_b_hs) begin
        r_bq_rd <= f_qinc(r_bq_rd);
        if (m_axi_bresp == 2'b00) r_byte_cnt <= r_byte_cnt + r_bq[r_bq_rd];
        else                      r_err      <= 1'b1;
      end
      case ({w_aw_hs, w_b_hs})
        2'b10:   r_out <= r_out + OW'(1);
        2'b01:   r_out <= r_out - OW'(1);
        default: r_out <= r_out;
      endcase
    end
  end

  assign m_axi_awid    = ID_WIDTH'(AWID_VALUE);
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_mem_data[r_rd];
  assign m_axi_wstrb   = r_mem_keep[r_rd];
  assign m_axi_wlast   = (r_state == S_W) && (r_beat == r_awlen);
  assign m_axi_wvalid  = (r_state == S_W) && !w_empty;
  assign m_axi_bready  = (r_out != '0);
  assign wr_ptr        = r_wr_ptr;
  assign byte_count    = r_byte_cnt;
  assign err           = r_err;
  assign busy          = !w_empty || (r_state != S_IDLE) || (r_out != '0);
  assign w_unused      = ^m_axi_bid;

endmodule
